// File: rtl/tim_vfsm.sv
// ---------------------------------------------------------------------------
// tim_vfsm -- vertical timing FSM for the CCD readout chain.
//
// On a start request it reads out one frame: a photodiode-to-VCCD charge
// transfer (third-level pulse on V2), then NLINES two-phase vertical line
// shifts. Each shift is followed by a line-active window of LINE_CLKS clocks
// during which the downstream horizontal FSM clocks the line out.
//
// Ports:
//   clk         in   system clock (only clock)
//   rst         in   synchronous, active-high reset
//   start       in   frame request, sampled only while idle
//   v1          out  vertical clock phase 1
//   v2          out  vertical clock phase 2
//   v2_3l       out  V2 third-level (transfer) enable
//   vact        out  line-active window to the horizontal FSM
//   firstline   out  high while vact is high for line 0
//   line_idx    out  index of the current line, 0..NLINES-1
//   busy        out  frame in progress
//   frame_done  out  one-cycle pulse at end of frame
// ---------------------------------------------------------------------------
module tim_vfsm #(
    parameter int unsigned NLINES    = 1650,
    parameter int unsigned LINE_CLKS = 24810,
    parameter int unsigned T_VS      = 40,
    parameter int unsigned T_XFER    = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        v1,
    output logic        v2,
    output logic        v2_3l,
    output logic        vact,
    output logic        firstline,
    output logic [11:0] line_idx,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_XFER_SU,
        S_XFER,
        S_XFER_HD,
        S_LS1,
        S_LS2,
        S_LGAP,
        S_LACT,
        S_DONE
    } state_t;

    // Segment counter reload values: a segment of N cycles loads N-1 and
    // the FSM leaves the segment when the counter reaches zero.
    localparam logic [15:0] VS_LOAD   = 16'(T_VS - 1);
    localparam logic [15:0] XFER_LOAD = 16'(T_XFER - 1);
    localparam logic [15:0] LINE_LOAD = 16'(LINE_CLKS - 1);
    localparam logic [11:0] LAST_LINE = 12'(NLINES - 1);

    state_t      state_q, state_d;
    logic [15:0] seg_cnt_q, seg_cnt_d;
    logic [11:0] line_idx_q, line_idx_d;

    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic v2_3l_q, v2_3l_d;
    logic vact_q, vact_d;
    logic firstline_q, firstline_d;
    logic busy_q, busy_d;
    logic frame_done_q, frame_done_d;

    logic seg_done;

    assign seg_done = (seg_cnt_q == 16'd0);

    // Next-state logic. The segment counter counts down by default; each
    // state only acts when its segment has expired, at which point it picks
    // the following state and reloads the counter for that segment's length.
    always_comb begin
        state_d    = state_q;
        seg_cnt_d  = seg_cnt_q;
        line_idx_d = line_idx_q;

        if (!seg_done) begin
            seg_cnt_d = seg_cnt_q - 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_XFER_SU;
                    seg_cnt_d = VS_LOAD;
                end
            end
            S_XFER_SU: begin
                if (seg_done) begin
                    state_d   = S_XFER;
                    seg_cnt_d = XFER_LOAD;
                end
            end
            S_XFER: begin
                if (seg_done) begin
                    state_d   = S_XFER_HD;
                    seg_cnt_d = VS_LOAD;
                end
            end
            S_XFER_HD: begin
                if (seg_done) begin
                    state_d    = S_LS1;
                    seg_cnt_d  = VS_LOAD;
                    line_idx_d = 12'd0;
                end
            end
            S_LS1: begin
                if (seg_done) begin
                    state_d   = S_LS2;
                    seg_cnt_d = VS_LOAD;
                end
            end
            S_LS2: begin
                if (seg_done) begin
                    state_d   = S_LGAP;
                    seg_cnt_d = VS_LOAD;
                end
            end
            S_LGAP: begin
                if (seg_done) begin
                    state_d   = S_LACT;
                    seg_cnt_d = LINE_LOAD;
                end
            end
            S_LACT: begin
                if (seg_done) begin
                    if (line_idx_q == LAST_LINE) begin
                        state_d   = S_DONE;
                        seg_cnt_d = 16'd0;
                    end else begin
                        state_d    = S_LS1;
                        seg_cnt_d  = VS_LOAD;
                        line_idx_d = line_idx_q + 12'd1;
                    end
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                seg_cnt_d  = 16'd0;
                line_idx_d = 12'd0;
            end
            default: begin
                state_d    = S_IDLE;
                seg_cnt_d  = 16'd0;
                line_idx_d = 12'd0;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs change on
    // the same edge as the state register. V1 and V2 are decoded from
    // disjoint state sets and V2 third-level only from a V2-high state, so
    // the driver never sees overlapping phases.
    always_comb begin
        v1_d         = (state_d == S_LS1);
        v2_d         = (state_d == S_XFER_SU) || (state_d == S_XFER) ||
                       (state_d == S_XFER_HD) || (state_d == S_LS2);
        v2_3l_d      = (state_d == S_XFER);
        vact_d       = (state_d == S_LACT);
        firstline_d  = (state_d == S_LACT) && (line_idx_d == 12'd0);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_DONE);
    end

    // State, counters and outputs in one register bank. Reset wins at any
    // edge, so a mid-frame reset drops straight to idle with no partial line
    // and no end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            seg_cnt_q    <= 16'd0;
            line_idx_q   <= 12'd0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            v2_3l_q      <= 1'b0;
            vact_q       <= 1'b0;
            firstline_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            seg_cnt_q    <= seg_cnt_d;
            line_idx_q   <= line_idx_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            v2_3l_q      <= v2_3l_d;
            vact_q       <= vact_d;
            firstline_q  <= firstline_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign v1         = v1_q;
    assign v2         = v2_q;
    assign v2_3l      = v2_3l_q;
    assign vact       = vact_q;
    assign firstline  = firstline_q;
    assign line_idx   = line_idx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tim_vfsm.sv
// ---------------------------------------------------------------------------
// tb_tim_vfsm -- directed self-checking bench for tim_vfsm.
//
// dut0 uses T_VS=4, T_XFER=8, LINE_CLKS=20, NLINES=3; dut1 uses all-ones
// parameters for the single-cycle-segment case. Cycle c is the clock period
// following the c-th edge after the edge that sampled start (that edge is 0).
// Expected waveforms are hand-derived cycle ranges for those parameters.
// ---------------------------------------------------------------------------
module tb_tim_vfsm;

    logic clk = 1'b0;
    logic rst;
    logic start0;
    logic start1;

    logic        v1_0, v2_0, v2_3l_0, vact_0, firstline_0, busy_0, frame_done_0;
    logic [11:0] line_idx_0;
    logic        v1_1, v2_1, v2_3l_1, vact_1, firstline_1, busy_1, frame_done_1;
    logic [11:0] line_idx_1;

    logic [18:0] obs0;
    logic [18:0] obs1;

    int compared;
    int mismatched;

    always #5 clk = ~clk;

    tim_vfsm #(
        .NLINES    (3),
        .LINE_CLKS (20),
        .T_VS      (4),
        .T_XFER    (8)
    ) dut0 (
        .clk        (clk),
        .rst        (rst),
        .start      (start0),
        .v1         (v1_0),
        .v2         (v2_0),
        .v2_3l      (v2_3l_0),
        .vact       (vact_0),
        .firstline  (firstline_0),
        .line_idx   (line_idx_0),
        .busy       (busy_0),
        .frame_done (frame_done_0)
    );

    tim_vfsm #(
        .NLINES    (1),
        .LINE_CLKS (1),
        .T_VS      (1),
        .T_XFER    (1)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .v1         (v1_1),
        .v2         (v2_1),
        .v2_3l      (v2_3l_1),
        .vact       (vact_1),
        .firstline  (firstline_1),
        .line_idx   (line_idx_1),
        .busy       (busy_1),
        .frame_done (frame_done_1)
    );

    // Packed view of each instance: {v1,v2,v2_3l,vact,firstline,busy,frame_done,line_idx}.
    assign obs0 = {v1_0, v2_0, v2_3l_0, vact_0, firstline_0, busy_0, frame_done_0, line_idx_0};
    assign obs1 = {v1_1, v2_1, v2_3l_1, vact_1, firstline_1, busy_1, frame_done_1, line_idx_1};

    function automatic logic in_rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // Reference frame for dut0: XFER_SU 1..4, XFER 5..12, XFER_HD 13..16,
    // then lines starting at 17, 49, 81 (LS1 4, LS2 4, LGAP 4, LACT 20),
    // DONE at 113, idle from 114.
    function automatic logic [18:0] exp_main(input int c);
        logic        e_v1, e_v2, e_v2_3l, e_vact, e_first, e_busy, e_done;
        logic [11:0] e_line;
        e_v1    = in_rng(c, 17, 20) || in_rng(c, 49, 52) || in_rng(c, 81, 84);
        e_v2    = in_rng(c, 1, 16) || in_rng(c, 21, 24) || in_rng(c, 53, 56) ||
                  in_rng(c, 85, 88);
        e_v2_3l = in_rng(c, 5, 12);
        e_vact  = in_rng(c, 29, 48) || in_rng(c, 61, 80) || in_rng(c, 93, 112);
        e_first = in_rng(c, 29, 48);
        e_busy  = in_rng(c, 1, 113);
        e_done  = (c == 113);
        if (in_rng(c, 49, 80)) begin
            e_line = 12'd1;
        end else if (in_rng(c, 81, 113)) begin
            e_line = 12'd2;
        end else begin
            e_line = 12'd0;
        end
        return {e_v1, e_v2, e_v2_3l, e_vact, e_first, e_busy, e_done, e_line};
    endfunction

    // With start held high the next frame begins one idle cycle after DONE.
    function automatic logic [18:0] exp_btb(input int c);
        if (c >= 115) begin
            return exp_main(c - 114);
        end
        return exp_main(c);
    endfunction

    // Reference frame for dut1 with every segment one cycle long.
    function automatic logic [18:0] exp_one(input int c);
        case (c)
            1:       return {7'b0100010, 12'd0};
            2:       return {7'b0110010, 12'd0};
            3:       return {7'b0100010, 12'd0};
            4:       return {7'b1000010, 12'd0};
            5:       return {7'b0100010, 12'd0};
            6:       return {7'b0000010, 12'd0};
            7:       return {7'b0001110, 12'd0};
            8:       return {7'b0000011, 12'd0};
            default: return 19'd0;
        endcase
    endfunction

    // Advance one clock and sample #1 after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int c,
                               input logic [18:0] observed,
                               input logic [18:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, c, observed, expected);
        end
    endtask

    task automatic checkInvariants(input string tag, input int c,
                                   input logic a_v1, input logic a_v2,
                                   input logic a_v2_3l);
        checkOutput({tag, "_v1v2"}, c, 19'(a_v1 & a_v2), 19'd0);
        checkOutput({tag, "_3l"}, c, 19'(a_v2_3l & ~a_v2), 19'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        start0     = 1'b0;
        start1     = 1'b0;

        // Reset held for three edges, then released.
        repeat (3) applyStimulus();
        rst = 1'b0;
        applyStimulus();
        checkOutput("reset0", 0, obs0, 19'd0);
        checkOutput("reset1", 0, obs1, 19'd0);

        // Full frame with a stray start pulse at cycle 50.
        start0 = 1'b1;
        applyStimulus();
        for (int c = 1; c <= 116; c++) begin
            checkOutput("frame", c, obs0, exp_main(c));
            checkInvariants("frame_inv", c, v1_0, v2_0, v2_3l_0);
            start0 = (c == 50);
            applyStimulus();
        end
        start0 = 1'b0;

        // Back-to-back frames with start held high.
        start0 = 1'b1;
        applyStimulus();
        for (int c = 1; c <= 120; c++) begin
            checkOutput("btb", c, obs0, exp_btb(c));
            applyStimulus();
        end
        start0 = 1'b0;
        rst    = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkOutput("btb_reset", 121, obs0, 19'd0);
        applyStimulus();

        // Mid-frame reset asserted during cycle 70.
        start0 = 1'b1;
        applyStimulus();
        start0 = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            checkOutput("midrst_pre", c, obs0, exp_main(c));
            rst = (c == 70);
            applyStimulus();
        end
        rst = 1'b0;
        for (int c = 71; c <= 130; c++) begin
            checkOutput("midrst_post", c, obs0, 19'd0);
            applyStimulus();
        end

        // Single-cycle segments on dut1.
        start1 = 1'b1;
        applyStimulus();
        start1 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            checkOutput("single", c, obs1, exp_one(c));
            checkInvariants("single_inv", c, v1_1, v2_1, v2_3l_1);
            applyStimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
